// File: rtl/fetch_btb_pkg.sv
// rtl/fetch_btb_pkg.sv - shared BTB sizing, allocation counter value and entry layout
package fetch_btb_pkg;

    localparam int         BTB_ENTRIES  = 16;
    localparam logic [1:0] BTB_CTR_INIT = 2'b10;
    localparam int         BTB_IDXW     = $clog2(BTB_ENTRIES);
    localparam int         BTB_TAGW     = 15 - BTB_IDXW;

    typedef struct packed {
        logic                valid;
        logic [BTB_TAGW-1:0] tag;
        logic [15:0]         target;
        logic [1:0]          ctr;
    } btb_entry_t;

endpackage

// File: rtl/sat_ctr2.sv
// rtl/sat_ctr2.sv - 2-bit saturating direction counter step
module sat_ctr2 (
    input  logic [1:0] ctr,
    input  logic       taken,
    output logic [1:0] ctr_next
);

    always_comb begin
        ctr_next = ctr;
        if (taken) begin
            if (ctr != 2'b11) ctr_next = ctr + 2'b01;
        end else begin
            if (ctr != 2'b00) ctr_next = ctr - 2'b01;
        end
    end

endmodule

// File: rtl/fetch_btb.sv
// rtl/fetch_btb.sv - direct-mapped BTB with combinational lookup and resolved-branch training
module fetch_btb
    import fetch_btb_pkg::*;
#(
    parameter int         ENTRIES  = BTB_ENTRIES,
    parameter logic [1:0] CTR_INIT = BTB_CTR_INIT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] i_pc,
    output logic        o_valid,
    output logic [15:0] o_BT,
    input  logic        i_upd_en,
    input  logic [15:0] i_upd_pc,
    input  logic [15:0] i_upd_target,
    input  logic        i_upd_taken,
    input  logic        i_flush
);

    localparam int IDXW = $clog2(ENTRIES);
    localparam int TAGW = 15 - IDXW;

    typedef struct packed {
        logic            valid;
        logic [TAGW-1:0] tag;
        logic [15:0]     target;
        logic [1:0]      ctr;
    } entry_t;

    // Register array rather than RAM: lookup must be readable in the same cycle.
    entry_t table_q [ENTRIES];

    logic [IDXW-1:0] lk_idx;
    logic [TAGW-1:0] lk_tag;
    entry_t          lk_ent;
    logic            lk_hit;

    logic [IDXW-1:0] up_idx;
    logic [TAGW-1:0] up_tag;
    entry_t          up_ent;
    logic            up_hit;
    logic [1:0]      up_ctr_next;

    // Instruction PCs are halfword aligned, so bit 0 carries no information.
    logic unused_pc_lsb;
    assign unused_pc_lsb = i_pc[0] ^ i_upd_pc[0];

    assign lk_idx = i_pc[IDXW:1];
    assign lk_tag = i_pc[15:IDXW+1];
    assign lk_ent = table_q[lk_idx];
    assign lk_hit = lk_ent.valid && (lk_ent.tag == lk_tag);

    assign o_valid = lk_hit && lk_ent.ctr[1];
    assign o_BT    = o_valid ? lk_ent.target : 16'h0000;

    assign up_idx = i_upd_pc[IDXW:1];
    assign up_tag = i_upd_pc[15:IDXW+1];
    assign up_ent = table_q[up_idx];
    assign up_hit = up_ent.valid && (up_ent.tag == up_tag);

    sat_ctr2 u_sat_ctr2 (
        .ctr      (up_ent.ctr),
        .taken    (i_upd_taken),
        .ctr_next (up_ctr_next)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_q[i] <= '0;
            end
        end else if (i_flush) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_q[i].valid <= 1'b0;
            end
        end else if (i_upd_en) begin
            if (up_hit) begin
                table_q[up_idx].ctr <= up_ctr_next;
                if (i_upd_taken) table_q[up_idx].target <= i_upd_target;
            end else if (i_upd_taken) begin
                // Taken miss replaces whatever alias occupied the slot.
                table_q[up_idx].valid  <= 1'b1;
                table_q[up_idx].tag    <= up_tag;
                table_q[up_idx].target <= i_upd_target;
                table_q[up_idx].ctr    <= CTR_INIT;
            end
        end
    end

endmodule

// File: tb/tb_fetch_btb.sv
// tb/tb_fetch_btb.sv - directed and randomized self-checking bench for fetch_btb
module tb_fetch_btb;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] i_pc;
    logic        o_valid;
    logic [15:0] o_BT;
    logic        i_upd_en;
    logic [15:0] i_upd_pc;
    logic [15:0] i_upd_target;
    logic        i_upd_taken;
    logic        i_flush;

    int vecs = 0;
    int errs = 0;

    // Reference table: one slot per (pc/2) mod 16, tag is pc/32.
    bit          m_valid [16];
    int          m_tag   [16];
    int          m_tgt   [16];
    int          m_ctr   [16];

    always #5 clk = ~clk;

    fetch_btb dut (
        .clk          (clk),
        .reset        (reset),
        .i_pc         (i_pc),
        .o_valid      (o_valid),
        .o_BT         (o_BT),
        .i_upd_en     (i_upd_en),
        .i_upd_pc     (i_upd_pc),
        .i_upd_target (i_upd_target),
        .i_upd_taken  (i_upd_taken),
        .i_flush      (i_flush)
    );

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        vecs++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", name, got, exp);
        end
    endtask

    function automatic void model_predict(input int pc, output logic v, output logic [15:0] bt);
        int slot = (pc / 2) % 16;
        v  = m_valid[slot] && (m_tag[slot] == pc / 32) && (m_ctr[slot] >= 2);
        bt = v ? 16'(m_tgt[slot]) : 16'h0000;
    endfunction

    function automatic void model_clock(input bit rs, input bit fl, input bit ue,
                                        input int up, input int ut, input bit tk);
        int slot = (up / 2) % 16;
        if (rs) begin
            for (int i = 0; i < 16; i++) begin
                m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 0;
            end
        end else if (fl) begin
            for (int i = 0; i < 16; i++) m_valid[i] = 0;
        end else if (ue) begin
            if (m_valid[slot] && m_tag[slot] == up / 32) begin
                if (tk) begin
                    m_ctr[slot] = (m_ctr[slot] == 3) ? 3 : m_ctr[slot] + 1;
                    m_tgt[slot] = ut;
                end else begin
                    m_ctr[slot] = (m_ctr[slot] == 0) ? 0 : m_ctr[slot] - 1;
                end
            end else if (tk) begin
                m_valid[slot] = 1; m_tag[slot] = up / 32; m_tgt[slot] = ut; m_ctr[slot] = 2;
            end
        end
    endfunction

    // One clock: drive, check pre-edge lookup against the model, clock both.
    task automatic cyc(input logic [15:0] pc, input logic ue, input logic [15:0] up,
                       input logic [15:0] ut, input logic tk, input logic fl, input logic rs);
        logic        ev;
        logic [15:0] ebt;
        i_pc = pc; i_upd_en = ue; i_upd_pc = up; i_upd_target = ut;
        i_upd_taken = tk; i_flush = fl; reset = rs;
        #1;
        if (!rs) begin
            model_predict(int'(pc), ev, ebt);
            chk("cyc_valid", {15'h0, o_valid}, {15'h0, ev});
            chk("cyc_bt", o_BT, ebt);
        end
        @(posedge clk);
        model_clock(rs, fl, ue, int'(up), int'(ut), tk);
        #1;
        reset = 1'b0; i_upd_en = 1'b0; i_flush = 1'b0;
    endtask

    task automatic upd(input logic [15:0] up, input logic [15:0] ut, input logic tk);
        cyc(16'h0000, 1'b1, up, ut, tk, 1'b0, 1'b0);
    endtask

    task automatic look(input logic [15:0] pc, input logic ev, input logic [15:0] ebt);
        i_pc = pc;
        #1;
        chk($sformatf("look_valid_%h", pc), {15'h0, o_valid}, {15'h0, ev});
        chk($sformatf("look_bt_%h", pc), o_BT, ebt);
    endtask

    initial begin
        reset = 1'b1; i_pc = '0; i_upd_en = 1'b0; i_upd_pc = '0;
        i_upd_target = '0; i_upd_taken = 1'b0; i_flush = 1'b0;
        @(posedge clk); #1;
        cyc(16'h0, 1'b1, 16'h0010, 16'h1234, 1'b1, 1'b0, 1'b1);
        cyc(16'h0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);

        for (int p = 0; p <= 16'h1E; p += 2) look(16'(p), 1'b0, 16'h0000);

        upd(16'h0010, 16'h0040, 1'b1);
        look(16'h0010, 1'b1, 16'h0040);
        look(16'h0030, 1'b0, 16'h0000);

        upd(16'h0010, 16'h0040, 1'b0);  look(16'h0010, 1'b0, 16'h0000);
        upd(16'h0010, 16'h0040, 1'b0);
        upd(16'h0010, 16'h0040, 1'b0);
        upd(16'h0010, 16'h0040, 1'b1);  look(16'h0010, 1'b0, 16'h0000);
        upd(16'h0010, 16'h0040, 1'b1);  look(16'h0010, 1'b1, 16'h0040);
        upd(16'h0010, 16'h0040, 1'b1);  look(16'h0010, 1'b1, 16'h0040);
        upd(16'h0010, 16'h0040, 1'b1);
        upd(16'h0010, 16'h0040, 1'b0);  look(16'h0010, 1'b1, 16'h0040);
        upd(16'h0010, 16'h0040, 1'b0);  look(16'h0010, 1'b0, 16'h0000);
        upd(16'h0010, 16'h0080, 1'b1);  look(16'h0010, 1'b1, 16'h0080);

        upd(16'h0030, 16'h0100, 1'b1);
        look(16'h0010, 1'b0, 16'h0000);
        look(16'h0030, 1'b1, 16'h0100);
        upd(16'h0050, 16'h0200, 1'b0);
        look(16'h0030, 1'b1, 16'h0100);
        look(16'h0050, 1'b0, 16'h0000);
        upd(16'h0030, 16'h0100, 1'b0);  look(16'h0030, 1'b0, 16'h0000);

        upd(16'h0004, 16'h0300, 1'b1);
        cyc(16'h0, 1'b1, 16'h0002, 16'h0400, 1'b1, 1'b1, 1'b0);
        for (int p = 0; p <= 16'h1E; p += 2) look(16'(p), 1'b0, 16'h0000);
        look(16'h0030, 1'b0, 16'h0000);

        upd(16'h0010, 16'h0044, 1'b1);
        upd(16'h0010, 16'h0044, 1'b0);
        i_upd_en = 1'b1; i_upd_pc = 16'h0010; i_upd_target = 16'h0044; i_upd_taken = 1'b1;
        look(16'h0010, 1'b0, 16'h0000);
        cyc(16'h0010, 1'b1, 16'h0010, 16'h0044, 1'b1, 1'b0, 1'b0);
        look(16'h0010, 1'b1, 16'h0044);

        cyc(16'h0010, 1'b1, 16'h0010, 16'h0044, 1'b1, 1'b0, 1'b1);
        look(16'h0010, 1'b0, 16'h0000);
        for (int p = 0; p <= 16'h1E; p += 2) look(16'(p), 1'b0, 16'h0000);

        // Small PC pool (4 tags x 16 slots) so hits, aliasing and training are frequent.
        for (int n = 0; n < 600; n++) begin
            logic [15:0] pc, up, ut;
            logic        ue, tk, fl, rs;
            pc = 16'($urandom_range(0, 63) * 2);
            up = 16'($urandom_range(0, 63) * 2);
            ut = 16'($urandom) & 16'hFFFE;
            ue = ($urandom_range(0, 3) != 0);
            tk = ($urandom_range(0, 2) != 0);
            fl = ($urandom_range(0, 59) == 0);
            rs = ($urandom_range(0, 149) == 0);
            cyc(pc, ue, up, ut, tk, fl, rs);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/fetch_btb.md
# fetch_btb

Direct-mapped branch target buffer with 2-bit saturating direction counters. It sits upstream of the fetch stage and supplies `o_valid`/`o_BT` for the current PC, so fetch can redirect speculatively in the same cycle. Resolved-branch updates from execute allocate and train entries, and a flush input invalidates the whole table.

## Interface
Parameters:
- `ENTRIES`, default 16: number of entries; a power of two, ≥2. `IDXW = $clog2(ENTRIES)`.
- `CTR_INIT`, default 2'b10: counter value written on allocation (weakly taken).

Ports:
- `clk`  in  1  single clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-high.
- `i_pc`  in  16  fetch PC to look up (bit 0 ignored).
- `o_valid`  out  1  predict taken: hit and counter MSB set.
- `o_BT`  out  16  predicted target; 0 when `o_valid`=0.
- `i_upd_en`  in  1  resolved-branch update strobe.
- `i_upd_pc`  in  16  PC of the resolved branch.
- `i_upd_target`  in  16  resolved target.
- `i_upd_taken`  in  1  resolved direction.
- `i_flush`  in  1  invalidate all entries.

## Operation
- Entry = {valid, tag[15-IDXW-1:0], target[15:0], ctr[1:0]}.
- Index = pc[IDXW:1]; tag = pc[15:IDXW+1].
- Lookup is purely combinational from registered table state. hit = valid[idx] && tag match. `o_valid` = hit && ctr[1]; `o_BT` = `o_valid` ? target : 16'h0000.
- Update on `i_upd_en`:
  - Hit and taken: ctr saturating increment (max 3); target ← `i_upd_target`.
  - Hit and not taken: ctr saturating decrement (min 0); target unchanged. The entry stays valid.
  - Miss and taken: allocate and overwrite the slot (valid=1, new tag, target, ctr=`CTR_INIT`). Any aliasing entry is replaced.
  - Miss and not taken: no change.
- `i_flush`: all valid ← 0. Tag, target and ctr are not required to clear.
- Priority: `reset` > `i_flush` > `i_upd_en`. An update in a flush cycle is dropped.

## Timing
- Lookup latency 0 cycles, combinational in `i_pc`.
- Update and flush are visible to lookup from the cycle after the posedge that samples them.
- No bypass: a lookup to the entry being updated in the same cycle returns the pre-update contents.
- Reset: all valid=0, ctr=0, target=0, tag=0. Hence `o_valid`=0 and `o_BT`=0 from the cycle after reset for any `i_pc`.
- Reset asserted mid-training discards all state. Updates during reset are ignored.
- No handshake: `i_upd_en` is a single-cycle strobe, and one update is accepted per cycle.

## Structure
- The shared package holds `BTB_ENTRIES` (default 16), `BTB_CTR_INIT`, and `btb_entry_t` (packed struct, `ENTRIES` as parameter via localparam widths). Fetch and execute already share this package.
- One natural sub-module: `sat_ctr2`, a pure combinational 2-bit saturating inc/dec function of (ctr, taken). The table is implemented as a register array, not RAM, because of the combinational read.

## Test plan
All cases use `ENTRIES`=16, so idx=pc[4:1] and tag=pc[15:5].
- Reset, then sweep `i_pc` = 0x0000..0x001E → `o_valid`=0, `o_BT`=0x0000 throughout.
- Update pc=0x0010, taken, target=0x0040 → next cycle lookup 0x0010 gives `o_valid`=1, `o_BT`=0x0040. Lookup 0x0030 (same idx 8, different tag) gives `o_valid`=0.
- Counter training from ctr=2:
  - not-taken → ctr 1, `o_valid`=0.
  - not-taken → 0; not-taken again → stays 0.
  - taken ×3 → 1, 2, 3, with `o_valid`=1 from ctr=2.
  - one more taken → stays 3.
  - taken with target 0x0080 → `o_BT`=0x0080.
- Aliasing: with 0x0010 valid, a taken update on 0x0030 with target 0x0100 → lookup 0x0010 misses (`o_valid`=0); lookup 0x0030 gives 0x0100 with ctr=2. A not-taken miss update on 0x0050 leaves the table unchanged.
- `i_flush` and `i_upd_en` (taken, pc 0x0002) in the same cycle → next cycle every lookup, including 0x0002, gives `o_valid`=0.
- Same-cycle lookup and update on 0x0010 (ctr 1 → 2) → that cycle `o_valid`=0, next cycle `o_valid`=1.
- Reset asserted in the cycle after training → all outputs 0.
